// File: rtl/pq_pkg.sv
// Shared types for the priority-queue command front-end.
// Key/value layout, opcodes and the buffered command bundle.
package pq_pkg;

  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
  localparam int KV_WIDTH  = KEY_WIDTH + VAL_WIDTH;

  typedef logic [KV_WIDTH-1:0] kv_t;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_ENQ     = 2'b01,
    OP_DEQ     = 2'b10,
    OP_ENQ_DEQ = 2'b11
  } op_t;

  typedef struct packed {
    op_t op;
    kv_t kv;
  } cmd_t;

endpackage

// File: rtl/pq_cmd_driver_if.sv
// Bus bundle between the command driver, its upstream,
// the priority queue it paces and the result consumer.
interface pq_cmd_driver_if;
  import pq_pkg::*;

  logic cmd_valid;
  logic cmd_ready;
  op_t  cmd_op;
  kv_t  cmd_kv;
  logic pq_enq;
  logic pq_deq;
  kv_t  pq_kvi;
  kv_t  pq_kvo;
  logic pq_empty;
  logic pq_full;
  logic res_valid;
  logic res_ready;
  kv_t  res_kv;
  logic busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_kv,
    input  pq_kvo, pq_empty, pq_full,
    input  res_ready,
    output cmd_ready,
    output pq_enq, pq_deq, pq_kvi,
    output res_valid, res_kv, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_kv,
    output pq_kvo, pq_empty, pq_full,
    output res_ready,
    input  cmd_ready,
    input  pq_enq, pq_deq, pq_kvi,
    input  res_valid, res_kv, busy
  );

endinterface

// File: rtl/pq_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra
// wrap bit so full and empty are told apart.
module pq_cmd_fifo
  import pq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer advance and storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pq_cmd_driver.sv
// Command front-end for a priority queue: buffers ops,
// paces PQ strobes and holds dequeued results.
module pq_cmd_driver
  import pq_pkg::*;
#(
  parameter int OP_SPACING = 4,
  parameter int CMD_DEPTH  = 4
) (
  input  logic clk,
  input  logic rst_n,
  pq_cmd_driver_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_t;

  localparam logic [3:0] GAP_INIT =
    4'((OP_SPACING > 1) ? OP_SPACING - 2 : 0);

  state_t     state;
  logic [3:0] cnt;
  cmd_t       head;
  cmd_t       din;
  logic       f_full;
  logic       f_empty;
  logic       push;
  logic       pop;
  logic       slot_free;
  logic       elig;
  logic       bypass;

  assign din.op    = bus.cmd_op;
  assign din.kv    = bus.cmd_kv;
  assign push      = bus.cmd_valid && !f_full &&
                     (bus.cmd_op != OP_NOP);
  assign pop       = elig || bypass;
  assign slot_free = !bus.res_valid || bus.res_ready;

  assign bus.cmd_ready = !f_full;
  assign bus.busy      = (state != ST_IDLE) || !f_empty;

  pq_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (f_full),
    .empty (f_empty)
  );

  // Decide whether the head command may go out this cycle.
  always_comb begin
    elig   = 1'b0;
    bypass = 1'b0;
    if (state == ST_IDLE && !f_empty) begin
      unique case (head.op)
        OP_ENQ: elig = !bus.pq_full;
        OP_DEQ: elig = !bus.pq_empty && slot_free;
        OP_ENQ_DEQ: begin
          elig   = !bus.pq_empty && slot_free;
          bypass = bus.pq_empty && slot_free;
        end
        default: ;
      endcase
    end
  end

  // Issue FSM with registered strobes and spacing counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bus.pq_enq <= 1'b0;
      bus.pq_deq <= 1'b0;
      bus.pq_kvi <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (elig) begin
            bus.pq_enq <= head.op[0];
            bus.pq_deq <= head.op[1];
            bus.pq_kvi <= head.op[0] ? head.kv : '0;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          bus.pq_enq <= 1'b0;
          bus.pq_deq <= 1'b0;
          bus.pq_kvi <= '0;
          if (OP_SPACING == 1) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_GAP;
            cnt   <= GAP_INIT;
          end
        end
        ST_GAP: begin
          if (cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result slot: a new load wins over a consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_kv    <= '0;
    end else if (state == ST_ISSUE && bus.pq_deq) begin
      bus.res_valid <= 1'b1;
      bus.res_kv    <= bus.pq_kvo;
    end else if (bypass) begin
      bus.res_valid <= 1'b1;
      bus.res_kv    <= head.kv;
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pq_cmd_driver.sv
// Directed bench for pq_cmd_driver with a small
// behavioural min-queue standing in for the PQ.
module tb_pq_cmd_driver;
  import pq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pq_cmd_driver_if bus ();

  pq_cmd_driver #(
    .OP_SPACING (4),
    .CMD_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_enq = 0;
  int   n_deq = 0;
  int   n_res = 0;
  int   min_gap = 1000;
  int   last_strb = -1;
  kv_t  last_res = '0;
  logic force_full = 1'b0;
  logic inj = 1'b0;
  kv_t  inj_kv = '0;
  kv_t  q [$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Strobe spacing, strobe counts and consumed results.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_strb = -1;
    end else begin
      if (bus.pq_enq) n_enq++;
      if (bus.pq_deq) n_deq++;
      if (bus.pq_enq || bus.pq_deq) begin
        if (last_strb >= 0 && cyc - last_strb < min_gap)
          min_gap = cyc - last_strb;
        last_strb = cyc;
      end
      if (bus.res_valid && bus.res_ready) begin
        n_res++;
        last_res = bus.res_kv;
      end
    end
  end

  // PQ model: top is the smallest {key,val}.
  initial begin
    logic e;
    logic d;
    logic ij;
    kv_t  k;
    kv_t  ik;
    int   mi;
    bus.pq_kvo   = '0;
    bus.pq_empty = 1'b1;
    bus.pq_full  = 1'b0;
    forever begin
      @(posedge clk);
      e  = bus.pq_enq;
      d  = bus.pq_deq;
      k  = bus.pq_kvi;
      ij = inj;
      ik = inj_kv;
      #1;
      if (!rst_n) begin
        q.delete();
      end else begin
        if (d && q.size() > 0) begin
          mi = 0;
          for (int i = 1; i < q.size(); i++)
            if (q[i] < q[mi]) mi = i;
          q.delete(mi);
        end
        if (e) q.push_back(k);
        if (ij) q.push_back(ik);
      end
      bus.pq_empty = (q.size() == 0);
      bus.pq_full  = force_full || (q.size() >= 8);
      if (q.size() == 0) begin
        bus.pq_kvo = '0;
      end else begin
        mi = 0;
        for (int i = 1; i < q.size(); i++)
          if (q[i] < q[mi]) mi = i;
        bus.pq_kvo = q[mi];
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input op_t op, input kv_t kv);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_kv    = kv;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready)
      check("cmd_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_kv    = '0;
    bus.res_ready = 1'b0;

    cycles(3);
    check("rst_pq_enq", {31'd0, bus.pq_enq}, 0);
    check("rst_pq_deq", {31'd0, bus.pq_deq}, 0);
    check("rst_pq_kvi", {16'd0, bus.pq_kvi}, 0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 0);
    check("rst_res_kv", {16'd0, bus.res_kv}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;

    // Three enqueues then a dequeue of the minimum.
    send(OP_ENQ, 16'h0F0F);
    send(OP_ENQ, 16'h0B0B);
    send(OP_ENQ, 16'h0909);
    send(OP_DEQ, 16'h0000);
    wait_idle("idle_a");
    check("a_n_enq", n_enq, 3);
    check("a_n_deq", n_deq, 1);
    check("a_n_res", n_res, 1);
    check("a_res_kv", {16'd0, last_res}, 32'h0909);
    send(OP_DEQ, 16'h0000);
    send(OP_DEQ, 16'h0000);
    wait_idle("idle_b");
    check("b_n_res", n_res, 3);
    check("b_res_kv", {16'd0, last_res}, 32'h0F0F);
    check("b_pq_empty", {31'd0, bus.pq_empty}, 1);

    // Dequeue against an empty PQ must wait.
    send(OP_DEQ, 16'h0000);
    cycles(12);
    check("c_no_deq", n_deq, 3);
    check("c_busy", {31'd0, bus.busy}, 1);
    inj_kv = 16'h0808;
    inj    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inj = 1'b0;
    wait_idle("idle_c");
    check("c_n_deq", n_deq, 4);
    check("c_res_kv", {16'd0, last_res}, 32'h0808);

    // Full PQ: ENQ stalls, ENQ_DEQ still issues.
    send(OP_ENQ, 16'h1414);
    wait_idle("idle_d");
    force_full = 1'b1;
    cycles(2);
    send(OP_ENQ_DEQ, 16'h0404);
    wait_idle("idle_e");
    check("e_n_enq", n_enq, 5);
    check("e_n_deq", n_deq, 5);
    check("e_res_kv", {16'd0, last_res}, 32'h1414);
    send(OP_ENQ, 16'h0303);
    send(OP_ENQ, 16'h0505);
    send(OP_ENQ, 16'h0606);
    check("f_ready_3", {31'd0, bus.cmd_ready}, 1);
    send(OP_ENQ, 16'h0707);
    check("f_ready_4", {31'd0, bus.cmd_ready}, 0);
    cycles(10);
    check("f_stalled", n_enq, 5);
    check("f_busy", {31'd0, bus.busy}, 1);
    force_full = 1'b0;
    wait_idle("idle_f");
    check("f_n_enq", n_enq, 9);
    check("f_ready", {31'd0, bus.cmd_ready}, 1);

    for (int i = 0; i < 5; i++) send(OP_DEQ, 16'h0000);
    wait_idle("idle_g");
    check("g_n_res", n_res, 10);
    check("g_res_kv", {16'd0, last_res}, 32'h0707);

    // ENQ_DEQ on an empty PQ bypasses the queue.
    @(negedge clk);
    bus.res_ready = 1'b0;
    send(OP_ENQ_DEQ, 16'h5A5A);
    @(posedge clk);
    #1;
    check("h_res_valid", {31'd0, bus.res_valid}, 1);
    check("h_res_kv", {16'd0, bus.res_kv}, 32'h5A5A);
    cycles(6);
    check("h_busy", {31'd0, bus.busy}, 0);
    check("h_n_enq", n_enq, 9);
    check("h_n_deq", n_deq, 10);

    // Held result blocks a DEQ until consumed.
    send(OP_ENQ, 16'h1E1E);
    send(OP_DEQ, 16'h0000);
    cycles(12);
    check("i_n_enq", n_enq, 10);
    check("i_no_deq", n_deq, 10);
    check("i_res_kv", {16'd0, bus.res_kv}, 32'h5A5A);
    check("i_res_valid", {31'd0, bus.res_valid}, 1);
    bus.res_ready = 1'b1;
    wait_idle("idle_i");
    check("i_n_deq", n_deq, 11);
    check("i_n_res", n_res, 12);
    check("i_res_kv2", {16'd0, last_res}, 32'h1E1E);

    // Reset while spacing with commands queued.
    @(negedge clk);
    bus.res_ready = 1'b0;
    send(OP_ENQ_DEQ, 16'h3232);
    cycles(2);
    check("j_res_held", {31'd0, bus.res_valid}, 1);
    send(OP_ENQ, 16'h2828);
    send(OP_ENQ, 16'h2929);
    send(OP_ENQ, 16'h2A2A);
    send(OP_ENQ, 16'h2B2B);
    check("j_n_enq", n_enq, 11);
    check("j_busy", {31'd0, bus.busy}, 1);
    rst_n = 1'b0;
    #1;
    check("j_pq_enq", {31'd0, bus.pq_enq}, 0);
    check("j_pq_kvi", {16'd0, bus.pq_kvi}, 0);
    check("j_res_valid", {31'd0, bus.res_valid}, 0);
    check("j_res_kv", {16'd0, bus.res_kv}, 0);
    check("j_busy0", {31'd0, bus.busy}, 0);
    check("j_cmd_ready", {31'd0, bus.cmd_ready}, 1);
    cycles(2);
    rst_n = 1'b1;
    cycles(10);
    check("j_flushed", n_enq, 11);
    check("j_idle", {31'd0, bus.busy}, 0);

    check("min_gap", {31'd0, (min_gap >= 4)}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
